// File: rtl/hart_key_conditioner_if.sv
// Key-conditioner signal bundle: frame strobe, raw push-buttons and conditioned press levels.
// The master drives strobe and buttons; the slave (the conditioner) drives the press levels.
interface hart_key_conditioner_if;
   logic startOfFrame;
   logic plus_key_raw;
   logic minus_key_raw;
   logic plus_is_pressed;
   logic minus_is_pressed;

   modport master (
      output startOfFrame, plus_key_raw, minus_key_raw,
      input  plus_is_pressed, minus_is_pressed
   );

   modport slave (
      input  startOfFrame, plus_key_raw, minus_key_raw,
      output plus_is_pressed, minus_is_pressed
   );
endinterface

// File: rtl/hart_key_conditioner.sv
// Two independent key channels: 2-FF synchroniser, debounce counter, frame-based press FSM.
// Define HART_KEY_AUTOREPEAT_EN for first-press/delay/auto-repeat; otherwise out follows deb.
module hart_key_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES      = 500000,
   parameter int unsigned REPEAT_DELAY_FRAMES  = 20,
   parameter int unsigned REPEAT_PERIOD_FRAMES = 1
) (
   input logic                   clk,
   input logic                   resetN,
   hart_key_conditioner_if.slave keys
);
   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0] raw;
   logic [1:0] pressed;
   logic       sof;

   assign raw = {keys.minus_key_raw, keys.plus_key_raw};
   assign sof = keys.startOfFrame;
   assign keys.plus_is_pressed  = pressed[0];
   assign keys.minus_is_pressed = pressed[1];

`ifdef HART_KEY_AUTOREPEAT_EN
   localparam int unsigned FMAX = (REPEAT_DELAY_FRAMES > REPEAT_PERIOD_FRAMES) ?
                                  REPEAT_DELAY_FRAMES : REPEAT_PERIOD_FRAMES;
   localparam int unsigned FW   = $clog2(FMAX + 1);

   typedef enum logic [1:0] {StIdle, StFirst, StDelay, StRepeat} state_e;
`else
   logic unused_cfg;
   assign unused_cfg = ^{sof, REPEAT_DELAY_FRAMES, REPEAT_PERIOD_FRAMES};
`endif

   for (genvar k = 0; k < 2; k++) begin : g_key
      logic [1:0]    sync_q;
      logic          deb_q, deb_d;
      logic [DW-1:0] cnt_q, cnt_d;

      // Counter runs only while the synced level disagrees with the debounced one.
      always_comb begin
         cnt_d = '0;
         deb_d = deb_q;
         if (sync_q[1] != deb_q) begin
            if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
               deb_d = sync_q[1];
            end else begin
               cnt_d = cnt_q + DW'(1);
            end
         end
      end

      always_ff @(posedge clk or negedge resetN) begin
         if (!resetN) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
         end else begin
            sync_q <= {sync_q[0], raw[k]};
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
         end
      end

`ifdef HART_KEY_AUTOREPEAT_EN
      state_e        state_q, state_d;
      logic          out_q, out_d;
      logic [FW-1:0] fcnt_q, fcnt_d;
      logic [FW-1:0] pcnt_q, pcnt_d;

      always_comb begin
         state_d = state_q;
         out_d   = out_q;
         fcnt_d  = fcnt_q;
         pcnt_d  = pcnt_q;
         // Release wins over any frame strobe in the same cycle.
         if (!deb_q) begin
            state_d = StIdle;
            out_d   = 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  state_d = StFirst;
                  out_d   = 1'b1;
               end
               StFirst: begin
                  if (sof) begin
                     state_d = StDelay;
                     out_d   = 1'b0;
                     fcnt_d  = '0;
                  end
               end
               StDelay: begin
                  if (sof) begin
                     if (fcnt_q == FW'(REPEAT_DELAY_FRAMES - 1)) begin
                        state_d = StRepeat;
                        out_d   = 1'b1;
                        pcnt_d  = '0;
                     end else if (fcnt_q != {FW{1'b1}}) begin
                        fcnt_d = fcnt_q + FW'(1);
                     end
                  end
               end
               StRepeat: begin
                  if (sof) begin
                     pcnt_d = (pcnt_q == FW'(REPEAT_PERIOD_FRAMES - 1)) ? '0 : pcnt_q + FW'(1);
                     out_d  = (pcnt_d == '0);
                  end
               end
               default: begin
                  state_d = StIdle;
                  out_d   = 1'b0;
               end
            endcase
         end
      end

      always_ff @(posedge clk or negedge resetN) begin
         if (!resetN) begin
            state_q <= StIdle;
            out_q   <= 1'b0;
            fcnt_q  <= '0;
            pcnt_q  <= '0;
         end else begin
            state_q <= state_d;
            out_q   <= out_d;
            fcnt_q  <= fcnt_d;
            pcnt_q  <= pcnt_d;
         end
      end
`else
      logic out_q;

      always_ff @(posedge clk or negedge resetN) begin
         if (!resetN) begin
            out_q <= 1'b0;
         end else begin
            out_q <= deb_q;
         end
      end
`endif

      assign pressed[k] = out_q;
   end
endmodule
